// File: rtl/wb_slave_mem.sv
// wb_slave_mem
//   Wishbone classic slave fronting a byte-writable array of 32-bit words.
//   A request is latched in IDLE. It then waits LATENCY cycles, counted in
//   WAIT, and completes with a single-cycle ack_o or err_o in RESP.
//   Addresses outside [BASE_ADDR, BASE_ADDR + 4*N_WORDS) complete with err_o.
//
// Parameters
//   BASE_ADDR : byte address of word 0 (4-byte aligned)
//   N_WORDS   : number of 32-bit words (power of two, 1..65536)
//   LATENCY   : wait cycles before the response (0..15)
//
// Ports
//   clk     in   1   clock, rising edge
//   rstn_i  in   1   asynchronous active-low reset
//   cyc_i   in   1   bus cycle active
//   stb_i   in   1   request strobe
//   we_i    in   1   1 = write, 0 = read
//   adr_i   in   32  byte address
//   sel_i   in   4   byte enables, bit n qualifies dat_i[8n+7:8n]
//   dat_i   in   32  write data
//   dat_o   out  32  read data, zero outside the response cycle
//   ack_o   out  1   successful completion
//   err_o   out  1   error completion (out-of-range address)
module wb_slave_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned N_WORDS   = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o
);

  // IW is the true index width (0 for a single word). AW is the storage
  // width of the index register, which is never narrower than one bit.
  localparam int unsigned IW = $clog2(N_WORDS);
  localparam int unsigned AW = (IW > 0) ? IW : 1;
  localparam int unsigned HW = 31 - IW;
  localparam logic [3:0]  LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [31:0]   r_dat;
  logic [AW-1:0] r_idx;
  logic          r_hit;
  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [N_WORDS];

  logic          w_accept;
  logic [32:0]   w_off;
  logic          w_hit_in;
  logic [AW-1:0] w_idx_in;
  logic          w_unused_bits;
  logic          w_hit_sel;
  logic [AW-1:0] w_idx_sel;
  logic          w_we_sel;
  logic          w_ack_nxt;
  logic          w_err_nxt;
  logic [31:0]   w_rdata_nxt;

  // Offset from BASE_ADDR, computed in 33 bits. Bit 32 set means the address
  // is below the base. Any bit set at or above IW+2 means the address is past
  // the top. A zero upper slice is therefore exactly the in-range condition.
  function automatic logic [32:0] offset_f(input logic [31:0] a);
    return {1'b0, a} - {1'b0, BASE_ADDR};
  endfunction

  assign w_accept      = (r_state == S_IDLE) && cyc_i && stb_i;
  assign w_off         = offset_f(adr_i);
  assign w_hit_in      = (w_off[32:IW+2] == {HW{1'b0}});
  assign w_idx_in      = w_off[AW+1:2];
  assign w_unused_bits = ^w_off[1:0];

  // FSM state register.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic. cyc_i low in WAIT abandons the request, and stb_i
  // is not looked at outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch and wait counter.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= 4'd0;
      r_we  <= 1'b0;
      r_sel <= 4'd0;
      r_dat <= 32'd0;
      r_idx <= {AW{1'b0}};
      r_hit <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= LAT_M1;
      r_we  <= we_i;
      r_sel <= sel_i;
      r_dat <= dat_i;
      r_idx <= w_idx_in;
      r_hit <= w_hit_in;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end else if (r_state != S_WAIT) begin
      r_cnt <= 4'd0;
    end
  end

  // FSM output logic: the next-cycle response. The outputs are registered, so
  // a LATENCY=0 request goes straight from IDLE to RESP. In that case the
  // live bus fields are used because the latch has not been loaded yet.
  always_comb begin
    w_hit_sel   = r_hit;
    w_idx_sel   = r_idx;
    w_we_sel    = r_we;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = 32'd0;
    if (r_state == S_IDLE) begin
      w_hit_sel = w_hit_in;
      w_idx_sel = w_idx_in;
      w_we_sel  = we_i;
    end else begin
      w_hit_sel = r_hit;
      w_idx_sel = r_idx;
      w_we_sel  = r_we;
    end
    if (w_state_nxt == S_RESP) begin
      if (w_hit_sel) begin
        w_ack_nxt = 1'b1;
        if (!w_we_sel) begin
          w_rdata_nxt = r_mem[w_idx_sel];
        end else begin
          w_rdata_nxt = 32'd0;
        end
      end else begin
        w_err_nxt = 1'b1;
      end
    end else begin
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      w_rdata_nxt = 32'd0;
    end
  end

  // Response registers.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  // Memory array, not reset. An in-range write commits at the end of RESP,
  // and only its enabled bytes change. Reset forces IDLE asynchronously, so a
  // transaction cut short by reset never reaches this write.
  always_ff @(posedge clk) begin
    if ((r_state == S_RESP) && r_we && r_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_sel[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_dat[8*b +: 8];
        end
      end
    end
  end

  assign dat_o = r_rdata;
  assign ack_o = r_ack;
  assign err_o = r_err;

endmodule

// File: tb/tb_wb_slave_mem.sv
module tb_wb_slave_mem;

  typedef struct {
    logic        ack;
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
    int          due;
  } exp_t;

  localparam int LAT_A = 3;
  localparam int LAT_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // instance A: BASE 0x1000, 1024 words, LATENCY 3
  logic        a_rstn, a_cyc, a_stb, a_we, a_ack, a_err, a_prev;
  logic [31:0] a_adr, a_dat_i, a_dat_o;
  logic [3:0]  a_sel;
  // instance B: BASE 0, 16 words, LATENCY 0
  logic        b_rstn, b_cyc, b_stb, b_we, b_ack, b_err, b_prev;
  logic [31:0] b_adr, b_dat_i, b_dat_o;
  logic [3:0]  b_sel;

  wb_slave_mem #(.BASE_ADDR(32'h0000_1000), .N_WORDS(1024), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .rstn_i(a_rstn), .cyc_i(a_cyc), .stb_i(a_stb), .we_i(a_we),
    .adr_i(a_adr), .sel_i(a_sel), .dat_i(a_dat_i), .dat_o(a_dat_o),
    .ack_o(a_ack), .err_o(a_err));

  wb_slave_mem #(.BASE_ADDR(32'h0000_0000), .N_WORDS(16), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .rstn_i(b_rstn), .cyc_i(b_cyc), .stb_i(b_stb), .we_i(b_we),
    .adr_i(b_adr), .sel_i(b_sel), .dat_i(b_dat_i), .dat_o(b_dat_o),
    .ack_o(b_ack), .err_o(b_err));

  exp_t qa[$];
  exp_t qb[$];
  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] bb_data [8] = '{32'h0123_4567, 32'h89AB_CDEF, 32'h1357_9BDF, 32'h2468_ACE0,
                               32'hFEDC_BA98, 32'h7654_3210, 32'h0F0F_F0F0, 32'hA5A5_5A5A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic int lat_of(input int inst);
    return (inst == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic set_bus(input int inst, input logic c, input logic s, input logic w,
                         input logic [31:0] ad, input logic [3:0] sl, input logic [31:0] d);
    if (inst == 0) begin
      a_cyc = c; a_stb = s; a_we = w; a_adr = ad; a_sel = sl; a_dat_i = d;
    end else begin
      b_cyc = c; b_stb = s; b_we = w; b_adr = ad; b_sel = sl; b_dat_i = d;
    end
  endtask

  task automatic push(input int inst, input exp_t e);
    if (inst == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // One complete request. Inputs are presented right after an edge, so the
  // accept happens at the next edge and the response is due 1+LATENCY cycles
  // after the presenting cycle. cyc stays high until the response cycle ends.
  task automatic req(input int inst, input logic w, input logic [31:0] ad, input logic [3:0] sl,
                     input logic [31:0] d, input logic e_err, input logic e_chk,
                     input logic [31:0] e_dat);
    exp_t e;
    @(posedge clk); #1;
    set_bus(inst, 1'b1, 1'b1, w, ad, sl, d);
    e.ack = ~e_err; e.err = e_err; e.chk_dat = e_chk; e.dat = e_dat;
    e.due = cyc_n + 1 + lat_of(inst);
    push(inst, e);
    @(posedge clk); #1;
    set_bus(inst, 1'b1, 1'b0, w, ad, sl, d);
    repeat (lat_of(inst)) @(posedge clk);
    @(posedge clk); #1;
    set_bus(inst, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic wr(input int inst, input logic [31:0] ad, input logic [3:0] sl,
                    input logic [31:0] d, input logic e_err);
    req(inst, 1'b1, ad, sl, d, e_err, e_err, 32'd0);
  endtask

  task automatic rd(input int inst, input logic [31:0] ad, input logic e_err, input logic [31:0] e_dat);
    req(inst, 1'b0, ad, 4'hF, 32'd0, e_err, 1'b1, e_err ? 32'd0 : e_dat);
  endtask

  // Monitor body for one instance and one cycle.
  task automatic mon(input int inst, input logic ack, input logic err, input logic [31:0] dat,
                     input logic prev_cyc);
    exp_t e;
    check($sformatf("inst%0d ack_err_both", inst), {31'd0, ack & err}, 32'd0);
    if (ack || err) begin
      check($sformatf("inst%0d resp_after_cyc_low", inst), {31'd0, prev_cyc}, 32'd1);
      if ((inst == 0 && qa.size() == 0) || (inst == 1 && qb.size() == 0)) begin
        n_checks++;
        n_err++;
        $display("FAIL inst%0d unexpected_resp: got ack=%b err=%b expected no response (cycle %0d)",
                 inst, ack, err, cyc_n);
      end else begin
        if (inst == 0) e = qa.pop_front();
        else e = qb.pop_front();
        check($sformatf("inst%0d resp_cycle", inst), 32'(cyc_n), 32'(e.due));
        check($sformatf("inst%0d ack", inst), {31'd0, ack}, {31'd0, e.ack});
        check($sformatf("inst%0d err", inst), {31'd0, err}, {31'd0, e.err});
        if (e.chk_dat) check($sformatf("inst%0d dat_o", inst), dat, e.dat);
      end
    end else begin
      check($sformatf("inst%0d dat_o_idle_zero", inst), dat, 32'd0);
    end
  endtask

  initial begin
    a_prev = 1'b0;
    b_prev = 1'b0;
    forever begin
      @(negedge clk);
      mon(0, a_ack, a_err, a_dat_o, a_prev);
      mon(1, b_ack, b_err, b_dat_o, b_prev);
      a_prev = a_cyc;
      b_prev = b_cyc;
    end
  end

  initial begin
    exp_t e;
    a_rstn = 1'b0;
    b_rstn = 1'b0;
    set_bus(0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_bus(1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset a_ack", {31'd0, a_ack}, 32'd0);
    check("reset a_err", {31'd0, a_err}, 32'd0);
    check("reset a_dat_o", a_dat_o, 32'd0);
    check("reset b_ack", {31'd0, b_ack}, 32'd0);
    check("reset b_err", {31'd0, b_err}, 32'd0);
    check("reset b_dat_o", b_dat_o, 32'd0);
    a_rstn = 1'b1;
    b_rstn = 1'b1;

    // ---- instance A ----
    wr(0, 32'h0000_1010, 4'hF, 32'hDEAD_BEEF, 1'b0);
    rd(0, 32'h0000_1010, 1'b0, 32'hDEAD_BEEF);
    wr(0, 32'h0000_1010, 4'b0101, 32'h1122_3344, 1'b0);
    rd(0, 32'h0000_1010, 1'b0, 32'hDE22_BE44);
    wr(0, 32'h0000_1010, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    rd(0, 32'h0000_1010, 1'b0, 32'hDE22_BE44);
    wr(0, 32'h0000_1FFC, 4'hF, 32'hCAFE_F00D, 1'b0);
    rd(0, 32'h0000_1FFC, 1'b0, 32'hCAFE_F00D);
    rd(0, 32'h0000_1FFF, 1'b0, 32'hCAFE_F00D);
    rd(0, 32'h0000_2000, 1'b1, 32'd0);
    rd(0, 32'hFFFF_FFFC, 1'b1, 32'd0);
    rd(0, 32'h0000_0FFC, 1'b1, 32'd0);
    wr(0, 32'h0000_1000, 4'hF, 32'h7777_0000, 1'b0);
    wr(0, 32'h0000_2000, 4'hF, 32'hBAD0_BAD0, 1'b1);
    rd(0, 32'h0000_1000, 1'b0, 32'h7777_0000);

    // abort: write dropped after two WAIT cycles, no response expected
    wr(0, 32'h0000_1020, 4'hF, 32'h0102_0304, 1'b0);
    @(posedge clk); #1;
    set_bus(0, 1'b1, 1'b1, 1'b1, 32'h0000_1020, 4'hF, 32'h5555_AAAA);
    @(posedge clk); #1;
    set_bus(0, 1'b1, 1'b0, 1'b1, 32'h0000_1020, 4'hF, 32'h5555_AAAA);
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_bus(0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    repeat (5) @(posedge clk);
    rd(0, 32'h0000_1020, 1'b0, 32'h0102_0304);

    // reset during WAIT: write abandoned, no response expected
    wr(0, 32'h0000_1030, 4'hF, 32'h0A0B_0C0D, 1'b0);
    @(posedge clk); #1;
    set_bus(0, 1'b1, 1'b1, 1'b1, 32'h0000_1030, 4'hF, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    set_bus(0, 1'b1, 1'b0, 1'b1, 32'h0000_1030, 4'hF, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    a_rstn = 1'b0;
    #2;
    check("midreset a_ack", {31'd0, a_ack}, 32'd0);
    check("midreset a_err", {31'd0, a_err}, 32'd0);
    check("midreset a_dat_o", a_dat_o, 32'd0);
    set_bus(0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(posedge clk); #1;
    a_rstn = 1'b1;
    repeat (6) @(posedge clk);
    rd(0, 32'h0000_1030, 1'b0, 32'h0A0B_0C0D);

    // ---- instance B ----
    for (int k = 0; k < 8; k++) wr(1, 32'(k * 4), 4'hF, bb_data[k], 1'b0);
    wr(1, 32'h0000_003C, 4'hF, 32'h600D_F00D, 1'b0);
    rd(1, 32'h0000_003C, 1'b0, 32'h600D_F00D);
    rd(1, 32'h0000_0040, 1'b1, 32'd0);

    // back-to-back reads, cyc/stb held high, sel zero
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      set_bus(1, 1'b1, 1'b1, 1'b0, 32'(k * 4), 4'h0, 32'd0);
      e.ack = 1'b1; e.err = 1'b0; e.chk_dat = 1'b1; e.dat = bb_data[k];
      e.due = cyc_n + 1;
      push(1, e);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    set_bus(1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

    repeat (10) @(posedge clk);
    #1;
    check("inst0 pending_responses", 32'(qa.size()), 32'd0);
    check("inst1 pending_responses", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
